uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 8, transmit FIFO depth in bytes; SHALL be a power of two.
REQ-004 SHALL have port CLK  input  1  system clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port io_sel  input  1  block selected: IO region and UART word address decoded upstream.
REQ-007 SHALL have port io_wstrb  input  1  write strobe, single-cycle, OR of the CPU write mask.
REQ-008 SHALL have port io_rstrb  input  1  read strobe, single-cycle.
REQ-009 SHALL have port io_wdata  input  32  write data; only bits [7:0] used.
REQ-010 SHALL have port io_rdata  output  32  status word; combinational from registered state.
REQ-011 SHALL have port tx  output  1  serial line, idle high, registered.

Function
REQ-012 SHALL derive DIV = floor(CLK_HZ/BAUD), 104 at the defaults; every serial bit SHALL last exactly DIV clocks.
REQ-013 Push: io_sel & io_wstrb SHALL write io_wdata[7:0] at the FIFO tail when count < DEPTH, or when count = DEPTH and a pop occurs in the same cycle.
REQ-014 A push rejected under REQ-013 SHALL drop the byte, leave FIFO contents unchanged, and set sticky flag ovf.
REQ-015 io_sel & io_rstrb SHALL clear ovf on that edge; a rejected push in the same cycle SHALL leave ovf = 1.
REQ-016 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-017 io_rdata SHALL be {28'b0, ovf, busy, empty, full}: full = (count = DEPTH), empty = (count = 0), busy = (state != IDLE) | !empty.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE: tx = 1; when !empty, SHALL pop the head byte into an 8-bit shift register, clear the bit counter and the divider, and go to START.
REQ-020 START: tx = 0 for DIV clocks, then go to DATA.
REQ-021 DATA: tx = shift[0], LSB first; after each DIV clocks SHALL shift right and increment the bit counter; after the 8th bit SHALL go to STOP.
REQ-022 STOP: tx = 1 for DIV clocks, then go to IDLE.
REQ-023 The IDLE-to-START pop SHALL occur on the first edge with !empty; back-to-back frames SHALL therefore have exactly one idle-high clock between the stop bit and the next start bit.
REQ-024 A write to an empty FIFO on edge E SHALL make tx low from edge E+2, since IDLE sees !empty at edge E+1.
REQ-025 The divider SHALL count DIV-1 down to 0 and reload on each bit boundary; no bit may be shortened or lengthened by FIFO activity.
REQ-026 Writes SHALL never disturb the frame in flight; only io_wdata[7:0] is stored.

Reset
REQ-027 reset SHALL take priority over all other inputs: state = IDLE, tx = 1, count = 0, pointers = 0, ovf = 0, divider and bit counter = 0.
REQ-028 reset asserted mid-frame SHALL abort the frame: tx = 1 after that edge, and queued bytes SHALL be discarded.
REQ-029 After reset deasserts, io_rdata SHALL read 32'h2 (empty only).

Verification
REQ-030 Reset, then write 0x55 -> tx low from edge E+2; line holds 0,1,0,1,0,1,0,1,0,1 for 104 clocks each, then IDLE; io_rdata = 0x2.
REQ-031 Write 0x41, 0x42, 0x43 on consecutive cycles -> three frames with exactly 1 idle clock between stop and start bits; busy = 1 until the final STOP ends.
REQ-032 While a frame is active, write 9 bytes -> first 8 accepted, full = 1; 9th dropped, ovf = 1; status read clears ovf; the dropped byte is never transmitted.
REQ-033 With FIFO full, write on the exact cycle IDLE pops -> byte accepted, count stays 8, ovf stays 0.
REQ-034 Assert reset during DATA bit 4 with 3 bytes queued -> tx = 1 next edge, io_rdata = 0x2, nothing transmitted afterwards.
REQ-035 Run with CLK_HZ = 1000, BAUD = 100 (DIV = 10) -> every bit lasts 10 clocks.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter (8N1) with a byte FIFO and an IO-mapped status word
module uart_tx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        io_sel,
  input  logic        io_wstrb,
  input  logic        io_rstrb,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        tx
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          ovf;

  logic full, empty, pop, wr_req, push;
  logic unused_wdata;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop      = (state == IDLE) && !empty;
  assign wr_req   = io_sel && io_wstrb;
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign push     = wr_req && (!full || pop);
  assign io_rdata = {28'b0, ovf, (state != IDLE) || !empty, empty, full};
  assign unused_wdata = ^io_wdata[31:8];

  always_ff @(posedge CLK) begin
    if (!reset && push) mem[tail] <= io_wdata[7:0];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (wr_req && !push)          ovf <= 1'b1;
      else if (io_sel && io_rstrb)  ovf <= 1'b0;

      // tx is the registered image of the state seen at this edge, one clock behind it.
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= mem[head];
            bit_cnt <= '0;
            div_cnt <= DIV_LAST;
            state   <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (div_cnt == '0) begin
            div_cnt <= DIV_LAST;
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (div_cnt == '0) begin
            div_cnt <= DIV_LAST;
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (div_cnt == '0) begin
            div_cnt <= DIV_LAST;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at DIV=104 and DIV=10
module tb_uart_tx;
  localparam int DIV_A = 104;
  localparam int DIV_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, io_sel, io_wstrb, io_rstrb, use_b, mon_en;
  logic [31:0] io_wdata;
  logic [31:0] rdata_a, rdata_b, rdata;
  logic        tx_a, tx_b, txm;

  assign txm   = use_b ? tx_b : tx_a;
  assign rdata = use_b ? rdata_b : rdata_a;

  uart_tx dut_a (
    .CLK(clk), .reset(reset), .io_sel(io_sel & ~use_b), .io_wstrb(io_wstrb),
    .io_rstrb(io_rstrb), .io_wdata(io_wdata), .io_rdata(rdata_a), .tx(tx_a)
  );

  uart_tx #(.CLK_HZ(1000), .BAUD(100)) dut_b (
    .CLK(clk), .reset(reset), .io_sel(io_sel & use_b), .io_wstrb(io_wstrb),
    .io_rstrb(io_rstrb), .io_wdata(io_wdata), .io_rdata(rdata_b), .tx(tx_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames_done = 0;
  int frames_started = 0;
  int last_start = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    io_wdata = {24'hA5A5A5, d};
    io_sel   = 1'b1;
    io_wstrb = 1'b1;
    @(posedge clk); #1;
    io_sel   = 1'b0;
    io_wstrb = 1'b0;
  endtask

  task automatic rd_status();
    io_sel   = 1'b1;
    io_rstrb = 1'b1;
    @(posedge clk); #1;
    io_sel   = 1'b0;
    io_rstrb = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("frames_done", frames_done, target);
  endtask

  task automatic wait_until(input int target, input int budget);
    int n = 0;
    while (cyc < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("cycle_align", cyc, target);
  endtask

  // Monitor: every cycle of a frame is compared, so bit lengths are checked exactly.
  initial begin : monitor
    bit         have_start;
    bit         abort;
    logic [7:0] exp_b, dec;
    logic [9:0] fr;
    int         errs, dv;
    have_start = 1'b0;
    forever begin
      if (!have_start) @(negedge clk);
      have_start = 1'b0;
      if (mon_en && txm === 1'b0) begin
        frames_started++;
        last_start = cyc;
        dv = use_b ? DIV_B : DIV_A;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          repeat (10 * dv) @(negedge clk);
        end else begin
          exp_b = exp_q.pop_front();
          fr    = {1'b1, exp_b, 1'b0};
          errs  = 0;
          dec   = '0;
          abort = 1'b0;
          for (int j = 0; j < 10 * dv; j++) begin
            if (j > 0) @(negedge clk);
            if (!mon_en) begin
              abort = 1'b1;
              break;
            end
            if (txm !== fr[j / dv]) errs++;
            if (j / dv >= 1 && j / dv <= 8 && j % dv == dv / 2) dec[j / dv - 1] = txm;
          end
          if (!abort) begin
            check("frame_line", errs, 0);
            check("frame_byte", dec, exp_b);
            @(negedge clk);
            check("stop_idle", txm, 1);
            frames_done++;
            if (exp_q.size() > 0 && mon_en) begin
              @(negedge clk);
              check("b2b_start", txm, 0);
              have_start = (txm === 1'b0);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int e, t0, s, fs;
    reset = 1'b1; io_sel = 1'b0; io_wstrb = 1'b0; io_rstrb = 1'b0;
    io_wdata = '0; use_b = 1'b0; mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_rdata_a", rdata_a, 32'h2);
    check("rst_rdata_b", rdata_b, 32'h2);
    check("rst_tx_a", tx_a, 1);
    check("rst_tx_b", tx_b, 1);
    mon_en = 1'b1;

    // single 0x55 frame and write-to-start latency
    exp_q.push_back(8'h55);
    wr(8'h55);
    e = cyc;
    wait_frames(1, 1200);
    check("start_latency", last_start - e, 2);
    check("idle_rdata", rdata, 32'h2);

    // three back-to-back frames
    t0 = frames_done;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    wr(8'h41); wr(8'h42); wr(8'h43);
    check("b2b_status", rdata, 32'h4);
    wait_frames(t0 + 3, 3 * 1100);
    check("after3_rdata", rdata, 32'h2);

    // reset in the middle of a data bit with three bytes queued
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h61 + 8'(i));
      wr(8'h61 + 8'(i));
    end
    check("queued_status", rdata, 32'h4);
    wait_until(last_start + 5 * DIV_A + 50, 1000);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_tx", tx_a, 1);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_mid_rdata", rdata, 32'h2);
    mon_en = 1'b1;
    fs = frames_started;
    repeat (1500) @(posedge clk);
    #1;
    check("no_tx_after_rst", frames_started, fs);
    check("rst_line_idle", tx_a, 1);

    // DIV = 10 instance
    use_b = 1'b1;
    t0 = frames_done;
    exp_q.push_back(8'hA3); exp_q.push_back(8'h0F);
    wr(8'hA3); wr(8'h0F);
    wait_frames(t0 + 2, 300);

    // overflow while a frame is in flight
    t0 = frames_done;
    exp_q.push_back(8'h11);
    wr(8'h11);
    repeat (3) @(posedge clk);
    #1;
    s = last_start;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      wr(8'h20 + 8'(i));
    end
    wr(8'hEE);
    check("full_ovf", rdata, 32'hD);
    rd_status();
    check("ovf_cleared", rdata, 32'h5);

    // write to a full FIFO on the exact edge IDLE pops
    wait_until(s + 10 * DIV_B - 1, 200);
    exp_q.push_back(8'h30);
    wr(8'h30);
    check("pop_push_full", rdata, 32'h5);
    wait_frames(t0 + 10, 10 * 110);
    check("drain_rdata", rdata, 32'h2);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
